// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and SRAM slave state encoding
package ahb_pkg;

  // Transfer type; only the upper bit matters for accepting a transfer.
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_DATA  = 3'd4,
    ST_ERR1     = 3'd5,
    ST_ERR2     = 3'd6
  } sram_state_e;

  // NONSEQ and SEQ both carry a real transfer.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bytelane_decode.sv
// rtl/ahb_bytelane_decode.sv - HSIZE and low address bits to byte lanes plus legality
module ahb_bytelane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       legal
);

  // Little-endian lane select; anything wider than a word or misaligned is illegal.
  always_comb begin
    be    = 4'b0000;
    legal = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        be    = 4'b0001 << addr_lo;
        legal = 1'b1;
      end
      HSIZE_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        legal = ~addr_lo[0];
      end
      HSIZE_WORD: begin
        be    = 4'b1111;
        legal = (addr_lo == 2'b00);
      end
      default: begin
        be    = 4'b0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave front-end driving a synchronous SRAM macro
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  in_HCLK,
  input  logic                  in_HRESET,
  input  logic                  in_HSEL_SRAMController,
  input  logic [31:0]           in_HADDR,
  input  logic [1:0]            in_HTRANS,
  input  logic                  in_HWRITE,
  input  logic [2:0]            in_HSIZE,
  input  logic [31:0]           in_HWDATA,
  input  logic                  in_HREADY,
  output logic                  out_HREADY_SRAMController,
  output logic [31:0]           out_HRDATA_SRAMController,
  output logic                  out_HRESP_SRAMController,
  output logic                  out_SRAM_CE,
  output logic                  out_SRAM_WE,
  output logic [3:0]            out_SRAM_BE,
  output logic [ADDR_WIDTH-1:0] out_SRAM_ADDR,
  output logic [31:0]           out_SRAM_WDATA,
  input  logic [31:0]           in_SRAM_RDATA
);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [3:0]            be_q;
  logic                  legal_q;
  logic [2:0]            wait_q, wait_d;

  logic                  accept;
  logic                  capture;
  logic [3:0]            addr_be;
  logic                  addr_legal;
  sram_state_e           accept_state;

  logic                  hready_out;
  logic                  hresp_out;
  logic                  ce_state;
  logic                  we_state;
  logic                  rdata_sel;

  // Upper address bits wrap; the decoder already bounds the region.
  logic unused_haddr;
  assign unused_haddr = ^in_HADDR[31:ADDR_WIDTH+2];

  ahb_bytelane_decode u_lane_decode (
    .hsize   (in_HSIZE),
    .addr_lo (in_HADDR[1:0]),
    .be      (addr_be),
    .legal   (addr_legal)
  );

  assign accept = in_HSEL_SRAMController & in_HREADY & htrans_active(in_HTRANS);

  // Destination of a newly accepted address phase, or IDLE when none is offered.
  always_comb begin
    accept_state = ST_IDLE;
    if (accept) begin
      if (!addr_legal) begin
        accept_state = ST_ERR1;
      end else if (in_HWRITE) begin
        accept_state = ST_WRITE;
      end else begin
        accept_state = ST_RD_ISSUE;
      end
    end
  end

  // State, wait counter and captured address-phase fields.
  always_ff @(posedge in_HCLK) begin
    if (in_HRESET) begin
      state_q <= ST_IDLE;
      wait_q  <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= 4'b0000;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (capture) begin
        addr_q  <= in_HADDR[ADDR_WIDTH+1:2];
        write_q <= in_HWRITE;
        be_q    <= addr_be;
        legal_q <= addr_legal;
      end
    end
  end

  // Next state and per-state bus/strobe controls.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    capture    = 1'b0;
    hready_out = 1'b1;
    hresp_out  = HRESP_OKAY;
    ce_state   = 1'b0;
    we_state   = 1'b0;
    rdata_sel  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture = accept;
        state_d = accept_state;
      end
      ST_WRITE: begin
        ce_state = 1'b1;
        we_state = write_q;
        capture  = accept;
        state_d  = accept_state;
      end
      ST_RD_ISSUE: begin
        hready_out = 1'b0;
        ce_state   = 1'b1;
        if (WAIT_STATES > 0) begin
          wait_d  = 3'(WAIT_STATES - 1);
          state_d = ST_RD_WAIT;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_WAIT: begin
        hready_out = 1'b0;
        if (wait_q == 3'd0) begin
          state_d = ST_RD_DATA;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_RD_DATA: begin
        rdata_sel = 1'b1;
        capture   = accept;
        state_d   = accept_state;
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = HRESP_ERROR;
        state_d    = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_out = HRESP_ERROR;
        capture   = accept;
        state_d   = accept_state;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_HREADY_SRAMController = hready_out;
  assign out_HRESP_SRAMController  = hresp_out;
  assign out_HRDATA_SRAMController = rdata_sel ? in_SRAM_RDATA : 32'h0000_0000;

  // A reset cycle must never strobe the macro, even if the old state would have.
  assign out_SRAM_CE    = ce_state & legal_q & ~in_HRESET;
  assign out_SRAM_WE    = out_SRAM_CE & we_state;
  assign out_SRAM_BE    = out_SRAM_CE ? be_q : 4'b0000;
  assign out_SRAM_ADDR  = addr_q;
  assign out_SRAM_WDATA = in_HWDATA;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - scoreboard bench for ahb_sram_slave against a byte-array memory model
module tb_ahb_sram_slave;

  localparam int AW    = 10;
  localparam int WS    = 2;
  localparam int NBYTE = 4 * (1 << AW);
  localparam int NRAND = 300;

  logic          in_HCLK;
  logic          in_HRESET;
  logic          in_HSEL_SRAMController;
  logic [31:0]   in_HADDR;
  logic [1:0]    in_HTRANS;
  logic          in_HWRITE;
  logic [2:0]    in_HSIZE;
  logic [31:0]   in_HWDATA;
  logic          in_HREADY;
  logic          out_HREADY_SRAMController;
  logic [31:0]   out_HRDATA_SRAMController;
  logic          out_HRESP_SRAMController;
  logic          out_SRAM_CE;
  logic          out_SRAM_WE;
  logic [3:0]    out_SRAM_BE;
  logic [AW-1:0] out_SRAM_ADDR;
  logic [31:0]   out_SRAM_WDATA;
  logic [31:0]   in_SRAM_RDATA;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .in_HCLK                   (in_HCLK),
    .in_HRESET                 (in_HRESET),
    .in_HSEL_SRAMController    (in_HSEL_SRAMController),
    .in_HADDR                  (in_HADDR),
    .in_HTRANS                 (in_HTRANS),
    .in_HWRITE                 (in_HWRITE),
    .in_HSIZE                  (in_HSIZE),
    .in_HWDATA                 (in_HWDATA),
    .in_HREADY                 (in_HREADY),
    .out_HREADY_SRAMController (out_HREADY_SRAMController),
    .out_HRDATA_SRAMController (out_HRDATA_SRAMController),
    .out_HRESP_SRAMController  (out_HRESP_SRAMController),
    .out_SRAM_CE               (out_SRAM_CE),
    .out_SRAM_WE               (out_SRAM_WE),
    .out_SRAM_BE               (out_SRAM_BE),
    .out_SRAM_ADDR             (out_SRAM_ADDR),
    .out_SRAM_WDATA            (out_SRAM_WDATA),
    .in_SRAM_RDATA             (in_SRAM_RDATA)
  );

  // Single-slave system: the muxed HREADY is this slave's own HREADYOUT.
  assign in_HREADY = out_HREADY_SRAMController;

  initial in_HCLK = 1'b0;
  always #5 in_HCLK = ~in_HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural SRAM macro: write strobed bytes, read data appears the cycle after CE.
  logic [31:0] sram_mem [0:(1<<AW)-1];
  logic        mem_clear = 1'b1;
  always @(posedge in_HCLK) begin
    if (mem_clear) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= 32'h0;
      in_SRAM_RDATA <= 32'h0;
    end else if (out_SRAM_CE) begin
      if (out_SRAM_WE) begin
        for (int b = 0; b < 4; b++) begin
          if (out_SRAM_BE[b]) sram_mem[out_SRAM_ADDR][8*b +: 8] <= out_SRAM_WDATA[8*b +: 8];
        end
      end else begin
        in_SRAM_RDATA <= sram_mem[out_SRAM_ADDR];
      end
    end
  end

  // Reference model: flat byte-addressed memory, updated in acceptance order.
  logic [7:0] ref_bytes [0:NBYTE-1];

  typedef struct {
    bit          err;
    bit          write;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] be;
    int          wait_cyc;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  task automatic model_accept(input txn_t t);
    exp_t e;
    int   base;
    int   n;
    int   lane;
    base       = int'(t.addr) & (NBYTE - 1);
    e.err      = (t.size > 3'd2) || ((int'(t.addr) % (1 << t.size)) != 0);
    e.write    = t.write;
    e.wdata    = t.wdata;
    e.addr     = base / 4;
    e.be       = 0;
    e.rdata    = 0;
    e.wait_cyc = e.err ? 1 : (t.write ? 0 : 1 + WS);
    if (!e.err) begin
      n = 1 << t.size;
      for (int i = 0; i < n; i++) begin
        lane = (base + i) % 4;
        e.be[lane] = 1'b1;
        if (t.write) ref_bytes[base + i] = t.wdata[8*lane +: 8];
      end
      if (!t.write) begin
        for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = ref_bytes[(base / 4) * 4 + i];
      end
    end
    sbq.push_back(e);
  endtask

  // Monitor: every cycle either checks the idle bus or the data phase at the head of the queue.
  bit   mon_en = 1'b0;
  exp_t mon_e;
  int   lo_cnt = 0;
  int   ce_cnt = 0;
  int   we_cnt = 0;
  always @(negedge in_HCLK) begin
    if (mon_en) begin
      if (sbq.size() == 0) begin
        chk("idle_hready", 32'(out_HREADY_SRAMController), 32'd1);
        chk("idle_hresp", 32'(out_HRESP_SRAMController), 32'd0);
        chk("idle_ce", 32'(out_SRAM_CE), 32'd0);
        chk("idle_hrdata", out_HRDATA_SRAMController, 32'h0);
      end else begin
        mon_e = sbq[0];
        chk("hresp", 32'(out_HRESP_SRAMController), 32'(mon_e.err));
        if (out_SRAM_CE) begin
          ce_cnt++;
          if (out_SRAM_WE) we_cnt++;
          chk("sram_addr", 32'(out_SRAM_ADDR), mon_e.addr);
          if (mon_e.write) begin
            chk("sram_be", 32'(out_SRAM_BE), mon_e.be);
            chk("sram_wdata", out_SRAM_WDATA, mon_e.wdata);
          end
        end
        if (out_HREADY_SRAMController) begin
          chk("wait_cycles", 32'(lo_cnt), 32'(mon_e.wait_cyc));
          chk("ce_count", 32'(ce_cnt), mon_e.err ? 32'd0 : 32'd1);
          chk("we_count", 32'(we_cnt), (mon_e.write && !mon_e.err) ? 32'd1 : 32'd0);
          if (!mon_e.write && !mon_e.err) chk("hrdata", out_HRDATA_SRAMController, mon_e.rdata);
          else chk("hrdata_zero", out_HRDATA_SRAMController, 32'h0);
          void'(sbq.pop_front());
          lo_cnt = 0;
          ce_cnt = 0;
          we_cnt = 0;
        end else begin
          lo_cnt++;
          chk("hrdata_wait_zero", out_HRDATA_SRAMController, 32'h0);
        end
      end
    end
  end

  task automatic drive(input txn_t t);
    in_HSEL_SRAMController = t.sel;
    in_HTRANS              = t.trans;
    in_HWRITE              = t.write;
    in_HSIZE               = t.size;
    in_HADDR               = t.addr;
  endtask

  function automatic txn_t mk(input bit w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.sel = 1'b1; t.trans = 2'b10; t.write = w; t.size = sz; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    int   word;
    int   lo;
    t.sel   = ($urandom_range(0, 9) != 0);
    r       = $urandom_range(0, 9);
    t.trans = (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : (r < 9) ? 2'b00 : 2'b01;
    t.write = $urandom_range(0, 1);
    t.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    word    = $urandom_range(0, 15) + ($urandom_range(0, 3) == 0 ? (1 << AW) - 16 : 0);
    if ($urandom_range(0, 6) == 0) lo = $urandom_range(0, 3);
    else if (t.size == 3'd0) lo = $urandom_range(0, 3);
    else if (t.size == 3'd1) lo = 2 * $urandom_range(0, 1);
    else lo = 0;
    t.addr  = ($urandom() & ~32'(NBYTE - 1)) | 32'(word * 4 + lo);
    t.wdata = $urandom();
    return t;
  endfunction

  txn_t plan[$];
  txn_t cur;
  txn_t idle_t;
  bit   rdy;
  int   cyc;

  initial begin
    idle_t = '{sel: 1'b0, trans: 2'b00, write: 1'b0, size: 3'd0, addr: 32'h0, wdata: 32'h0};
    for (int i = 0; i < NBYTE; i++) ref_bytes[i] = 8'h00;
    drive(idle_t);
    in_HWDATA = 32'h0;
    in_HRESET = 1'b1;

    // Two reset cycles; outputs checked after the first reset edge.
    @(posedge in_HCLK);
    @(negedge in_HCLK);
    chk("rst_hready", 32'(out_HREADY_SRAMController), 32'd1);
    chk("rst_hresp", 32'(out_HRESP_SRAMController), 32'd0);
    chk("rst_hrdata", out_HRDATA_SRAMController, 32'h0);
    chk("rst_ce", 32'(out_SRAM_CE), 32'd0);
    chk("rst_we", 32'(out_SRAM_WE), 32'd0);
    chk("rst_be", 32'(out_SRAM_BE), 32'd0);
    @(posedge in_HCLK);
    #1;
    in_HRESET = 1'b0;
    mem_clear = 1'b0;
    mon_en    = 1'b1;

    // Directed sequence first, then randomized traffic.
    plan.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
    plan.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    plan.push_back(mk(1'b1, 3'd0, 32'h13, 32'hAB000000));
    plan.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0));
    plan.push_back(mk(1'b0, 3'd2, 32'h12, 32'h0));
    plan.push_back(mk(1'b1, 3'd2, 32'h20, 32'h12345678));
    plan.push_back(mk(1'b0, 3'd2, 32'h20, 32'h0));
    plan.push_back(mk(1'b1, 3'd1, 32'h16, 32'hCAFE0000));
    plan.push_back(mk(1'b0, 3'd1, 32'h15, 32'h0));
    plan.push_back(mk(1'b0, 3'd2, 32'h14, 32'h0));
    for (int i = 0; i < NRAND; i++) plan.push_back(rand_txn());

    cur = idle_t;
    cyc = 0;
    while ((plan.size() > 0 || sbq.size() > 0 || (cur.sel && cur.trans[1])) && cyc < 20000) begin
      @(negedge in_HCLK);
      rdy = out_HREADY_SRAMController;
      @(posedge in_HCLK);
      #1;
      cyc++;
      if (rdy) begin
        if (cur.sel && cur.trans[1]) model_accept(cur);
        in_HWDATA = cur.wdata;
        cur = (plan.size() > 0) ? plan.pop_front() : idle_t;
        drive(cur);
      end
    end
    chk("traffic_timeout", 32'(cyc < 20000), 32'd1);
    @(negedge in_HCLK);
    mon_en = 1'b0;
    sbq.delete();

    // Reset while a read sits in its wait states.
    @(posedge in_HCLK);
    #1;
    drive(mk(1'b0, 3'd2, 32'h10, 32'h0));
    @(posedge in_HCLK);
    #1;
    drive(idle_t);
    @(negedge in_HCLK);
    chk("rdissue_ce", 32'(out_SRAM_CE), 32'd1);
    chk("rdissue_hready", 32'(out_HREADY_SRAMController), 32'd0);
    @(posedge in_HCLK);
    #1;
    in_HRESET = 1'b1;
    @(negedge in_HCLK);
    chk("rdwait_rst_ce", 32'(out_SRAM_CE), 32'd0);
    @(posedge in_HCLK);
    #1;
    in_HRESET = 1'b0;
    @(negedge in_HCLK);
    chk("post_rst_hready", 32'(out_HREADY_SRAMController), 32'd1);
    chk("post_rst_hresp", 32'(out_HRESP_SRAMController), 32'd0);
    chk("post_rst_hrdata", out_HRDATA_SRAMController, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_ce", 32'(out_SRAM_CE), 32'd0);
      chk("post_rst_idle_hready", 32'(out_HREADY_SRAMController), 32'd1);
      @(negedge in_HCLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave front-end for the on-chip synchronous SRAM macro.
- Downstream of the address decoder; upstream of the slave-to-master mux.
- Produces the SRAMController HREADY/HRDATA/HRESP that the mux selects, and consumes the muxed HREADY.
- Converts pipelined AHB address/data phases into single-cycle SRAM strobes, with zero-wait writes, configurable read wait states and a two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_WIDTH, 10, SRAM word-address bits (depth = 2^ADDR_WIDTH words of 32 bits).
- WAIT_STATES, 0, extra read data-phase cycles inserted before data is returned (0..7).

Ports:
- in_HCLK  input  1  system clock; all logic on the rising edge.
- in_HRESET  input  1  synchronous, active-high reset.
- in_HSEL_SRAMController  input  1  slave select from the address decoder.
- in_HADDR  input  32  address; only [ADDR_WIDTH+1:0] is used.
- in_HTRANS  input  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- in_HWRITE  input  1  1 = write.
- in_HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
- in_HWDATA  input  32  write data, valid in the data phase.
- in_HREADY  input  1  muxed HREADY from the slave-to-master mux.
- out_HREADY_SRAMController  output  1  slave HREADYOUT.
- out_HRDATA_SRAMController  output  32  read data.
- out_HRESP_SRAMController  output  1  0 = OKAY, 1 = ERROR.
- out_SRAM_CE  output  1  SRAM access strobe, one cycle per access.
- out_SRAM_WE  output  1  write enable, qualified by CE.
- out_SRAM_BE  output  4  byte-lane enables, little-endian.
- out_SRAM_ADDR  output  ADDR_WIDTH  word address (HADDR[ADDR_WIDTH+1:2]).
- out_SRAM_WDATA  output  32  write data, passthrough of in_HWDATA.
- in_SRAM_RDATA  input  32  SRAM data; valid from the cycle after a read CE, held until the next CE.

Behaviour:
- Reset: synchronous on in_HRESET at a clock edge.
  - State IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; CE=0; WE=0; BE=0.
  - All registered address, size and direction fields cleared; wait counter=0.
  - Reset mid-transfer aborts the transfer; no CE is issued in or after the reset cycle.
- Accept: an address phase is accepted at a rising edge when HSEL && in_HREADY && HTRANS[1].
  - On accept, register the address, HWRITE, HSIZE and a legality flag.
  - IDLE/BUSY transfers with HSEL=1 get a zero-wait OKAY and cause no SRAM access.
- Illegal transfer: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_DATA, ERR1, ERR2.
- IDLE:
  - HREADYOUT=1.
  - On accept go to ERR1 if illegal, else WRITE if HWRITE, else RD_ISSUE.
- WRITE (1 cycle, zero-wait):
  - CE=1, WE=1, BE from the registered size/address, WDATA=in_HWDATA, HREADYOUT=1.
  - Next state is chosen by the same accept rule as IDLE; falls back to IDLE if nothing is accepted.
- RD_ISSUE:
  - CE=1, WE=0, HREADYOUT=0.
  - Go to RD_WAIT if WAIT_STATES>0 (load counter=WAIT_STATES-1), else RD_DATA.
- RD_WAIT:
  - HREADYOUT=0, no CE.
  - Decrement the counter; go to RD_DATA when it reaches 0.
- RD_DATA:
  - HREADYOUT=1, HRDATA=in_SRAM_RDATA (full word; the master selects lanes).
  - Accept rule as in IDLE.
- HRDATA is 0 in every state other than RD_DATA.
- Read data phase length = 2+WAIT_STATES cycles; write data phase = 1 cycle.
- ERR1: HREADYOUT=0, HRESP=1, no CE; always go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1; accept rule as in IDLE.
- Byte enables:
  - size 0: 1<<HADDR[1:0].
  - size 1: HADDR[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
- Hazards: read-after-write to the same address returns the new data. The write CE in cycle N precedes the read CE in cycle N+1 or later, so no forwarding is needed.
- Address outside the SRAM: upper bits are ignored (wrap), because the decoder bounds the region.
- HSEL drop during a data phase is ignored; a data phase always completes.

Decomposition:
- Shared ahb_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE encodings.
  - HRESP OKAY/ERROR.
  - FSM state encoding (3-bit).
- One natural sub-module, ahb_bytelane_decode: combinational HSIZE + HADDR[1:0] to BE[3:0] plus the legality flag, reusable by other slaves.

Test Plan:
- Reset with in_HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=0, CE=0, HRDATA=0, state IDLE.
- Word write NONSEQ to 0x10, HWDATA=0xDEADBEEF -> next cycle CE=1, WE=1, ADDR=4, BE=4'b1111, WDATA=0xDEADBEEF, HREADYOUT=1.
- Word read of 0x10 back-to-back after that write, WAIT_STATES=0 -> RD_ISSUE has HREADYOUT=0; next cycle HREADYOUT=1 and HRDATA=0xDEADBEEF. Repeat with WAIT_STATES=2 -> HREADYOUT low for exactly 3 cycles.
- Byte write to 0x13 with HWDATA=0xAB000000 -> BE=4'b1000. A following word read of 0x10 returns 0xABADBEEF.
- Word access to 0x12 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); no CE in either cycle. A NONSEQ accepted in ERR2 proceeds normally.
- Read in flight, assert in_HRESET in RD_WAIT -> next cycle IDLE, HREADYOUT=1, CE=0, HRDATA=0; no further CE.
